// File: rtl/dma_bus_arbiter.sv
// Arbitrates the shared 6502/MARIA address bus: halts the CPU on a DMA request,
// hands the bus to MARIA once the CPU lets go, then returns it after a holdoff.
module dma_bus_arbiter #(
    parameter int HOLDOFF_CYCLES = 1,
    parameter int HALT_TIMEOUT   = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             pclk0,
    input  logic             pclk1,
    input  logic             halt_enable,
    input  logic             dma_req,
    input  logic             dma_end,
    input  logic             cpu_released,
    input  logic [15:0]      cpu_ab,
    input  logic             cpu_rwn,
    input  logic [15:0]      maria_ab,
    output logic             halt_n,
    output logic             dma_grant,
    output logic [15:0]      ab,
    output logic             rw,
    output logic [CNT_W-1:0] dma_cycles,
    output logic             halt_timeout
);

    localparam int WAIT_W = (HALT_TIMEOUT > 0) ? $clog2(HALT_TIMEOUT + 1) : 1;
    localparam int HOLD_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(HALT_TIMEOUT);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLDOFF_CYCLES);
    localparam logic [CNT_W-1:0]  LEN_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALTING,
        S_DMA,
        S_RELEASE,
        S_HOLDOFF
    } state_t;

    state_t            state_reg, state_next;
    logic              halt_n_reg, halt_n_next;
    logic              grant_reg, grant_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0]  len_reg, len_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [CNT_W-1:0]  dma_cycles_reg, dma_cycles_next;
    logic              timeout_reg, timeout_next;
    logic [15:0]       last_ab_reg;

    logic [WAIT_W-1:0] wait_inc;
    logic [CNT_W-1:0]  len_inc;

    // Saturating increments, qualified by the Phi1 enable
    assign wait_inc = (pclk1 && (wait_reg != WAIT_MAX)) ? wait_reg + WAIT_W'(1) : wait_reg;
    assign len_inc  = (pclk1 && (len_reg != LEN_MAX)) ? len_reg + CNT_W'(1) : len_reg;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            halt_n_reg     <= 1'b1;
            grant_reg      <= 1'b0;
            wait_reg       <= '0;
            len_reg        <= '0;
            hold_reg       <= '0;
            dma_cycles_reg <= '0;
            timeout_reg    <= 1'b0;
            last_ab_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            halt_n_reg     <= halt_n_next;
            grant_reg      <= grant_next;
            wait_reg       <= wait_next;
            len_reg        <= len_next;
            hold_reg       <= hold_next;
            dma_cycles_reg <= dma_cycles_next;
            timeout_reg    <= timeout_next;
            last_ab_reg    <= ab;
        end
    end

    always_comb begin
        state_next      = state_reg;
        halt_n_next     = halt_n_reg;
        grant_next      = grant_reg;
        wait_next       = wait_reg;
        len_next        = len_reg;
        hold_next       = hold_reg;
        dma_cycles_next = dma_cycles_reg;
        timeout_next    = timeout_reg;

        case (state_reg)
            S_IDLE: begin
                if (pclk1 && dma_req && halt_enable) begin
                    state_next  = S_HALTING;
                    halt_n_next = 1'b0;
                    wait_next   = '0;
                end
            end

            S_HALTING: begin
                wait_next = wait_inc;
                if (wait_inc == WAIT_MAX) begin
                    timeout_next = 1'b1;
                end
                // Release takes priority over a dropped request; the grant
                // is held off across a Phi2 enable so it never coincides with it.
                if (cpu_released) begin
                    if (!pclk0) begin
                        state_next = S_DMA;
                        grant_next = 1'b1;
                        len_next   = '0;
                    end
                end else if (!dma_req) begin
                    state_next  = S_RELEASE;
                    halt_n_next = 1'b1;
                end
            end

            S_DMA: begin
                len_next = len_inc;
                if (dma_end) begin
                    state_next      = S_RELEASE;
                    halt_n_next     = 1'b1;
                    grant_next      = 1'b0;
                    dma_cycles_next = len_inc;
                end
            end

            S_RELEASE: begin
                if (!cpu_released) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_HOLDOFF;
                        hold_next  = HOLD_INIT;
                    end
                end
            end

            S_HOLDOFF: begin
                if (hold_reg == '0) begin
                    state_next = S_IDLE;
                end else if (pclk1) begin
                    hold_next = hold_reg - HOLD_W'(1);
                end
            end

            default: begin
                state_next  = S_IDLE;
                halt_n_next = 1'b1;
                grant_next  = 1'b0;
            end
        endcase
    end

    // With the CPU off the bus but no grant yet (or after it), park on the last address
    always_comb begin
        case ({cpu_released, grant_reg})
            2'b10:   ab = last_ab_reg;
            2'b11:   ab = maria_ab;
            default: ab = cpu_ab;
        endcase
    end

    assign rw           = cpu_released ? 1'b1 : cpu_rwn;
    assign halt_n       = halt_n_reg;
    assign dma_grant    = grant_reg;
    assign dma_cycles   = dma_cycles_reg;
    assign halt_timeout = timeout_reg;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: Phi1/Phi2 enables every 4 clk_sys,
// with Phi1 on phase 0 and Phi2 on phase 2.
module tb_dma_bus_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        pclk0, pclk1;
    logic        halt_enable, dma_req, dma_end, cpu_released, cpu_rwn;
    logic [15:0] cpu_ab, maria_ab, ab;
    logic        halt_n, dma_grant, rw, halt_timeout;
    logic [7:0]  dma_cycles;

    int n_cmp = 0;
    int n_err = 0;
    int phase;

    dma_bus_arbiter #(
        .HOLDOFF_CYCLES(1),
        .HALT_TIMEOUT  (8),
        .CNT_W         (8)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .pclk0       (pclk0),
        .pclk1       (pclk1),
        .halt_enable (halt_enable),
        .dma_req     (dma_req),
        .dma_end     (dma_end),
        .cpu_released(cpu_released),
        .cpu_ab      (cpu_ab),
        .cpu_rwn     (cpu_rwn),
        .maria_ab    (maria_ab),
        .halt_n      (halt_n),
        .dma_grant   (dma_grant),
        .ab          (ab),
        .rw          (rw),
        .dma_cycles  (dma_cycles),
        .halt_timeout(halt_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    // Enables change on the falling edge so each is valid for exactly one rising edge
    initial begin
        phase = 3;
        pclk0 = 1'b0;
        pclk1 = 1'b0;
        forever begin
            @(negedge clk_sys);
            phase = (phase + 1) % 4;
            pclk1 = (phase == 0);
            pclk0 = (phase == 2);
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Returns just after a rising edge at which pclk1 was active
    task automatic pclk1_edge();
        do tick(); while (pclk1 !== 1'b1);
    endtask

    task automatic wait_halt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (halt_n === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dma_grant === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        halt_enable = 1'b0; dma_req = 1'b0; dma_end = 1'b0;
        cpu_released = 1'b0; cpu_rwn = 1'b0;
        cpu_ab = 16'hA5A5; maria_ab = 16'h0000;
        repeat (3) tick();
        n_cmp++; if (halt_n !== 1'b1) begin n_err++; $display("FAIL reset_halt_n: got %b want 1", halt_n); end
        n_cmp++; if (dma_grant !== 1'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0", dma_grant); end
        n_cmp++; if (dma_cycles !== 8'd0) begin n_err++; $display("FAIL reset_dma_cycles: got %0d want 0", dma_cycles); end
        n_cmp++; if (halt_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", halt_timeout); end
        n_cmp++; if (ab !== 16'hA5A5) begin n_err++; $display("FAIL reset_ab: got %h want a5a5", ab); end
        n_cmp++; if (rw !== 1'b0) begin n_err++; $display("FAIL reset_rw: got %b want 0", rw); end
        reset = 1'b0;
        $display("reset: halt_n=%b grant=%b dma_cycles=%0d", halt_n, dma_grant, dma_cycles);
    endtask

    task automatic test_halt_grant();
        bit ok;
        cpu_ab = 16'h1234; cpu_rwn = 1'b0; maria_ab = 16'h1F00;
        halt_enable = 1'b1; dma_req = 1'b1;
        pclk1_edge();
        n_cmp++; if (halt_n !== 1'b0) begin n_err++; $display("FAIL halt_first_pclk1: got %b want 0", halt_n); end
        n_cmp++; if (dma_grant !== 1'b0) begin n_err++; $display("FAIL grant_before_release: got %b want 0", dma_grant); end
        repeat (2) pclk1_edge();
        n_cmp++; if (halt_n !== 1'b0) begin n_err++; $display("FAIL halt_held: got %b want 0", halt_n); end
        cpu_released = 1'b1;
        #1;
        n_cmp++; if (ab !== 16'h1234) begin n_err++; $display("FAIL ab_parked: got %h want 1234", ab); end
        n_cmp++; if (rw !== 1'b1) begin n_err++; $display("FAIL rw_released: got %b want 1", rw); end
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL grant_timeout: got grant=%b want 1", dma_grant); end
        n_cmp++; if (ab !== 16'h1F00) begin n_err++; $display("FAIL ab_maria: got %h want 1f00", ab); end
        n_cmp++; if (rw !== 1'b1) begin n_err++; $display("FAIL rw_dma: got %b want 1", rw); end
        $display("halt_grant: halt_n=%b grant=%b ab=%h rw=%b", halt_n, dma_grant, ab, rw);
    endtask

    task automatic test_dma_length();
        repeat (2) pclk1_edge();
        maria_ab = 16'h1F04;
        repeat (3) pclk1_edge();
        dma_end = 1'b1; dma_req = 1'b0;
        tick();
        dma_end = 1'b0;
        cpu_ab = 16'h2222;
        #1;
        n_cmp++; if (dma_cycles !== 8'd5) begin n_err++; $display("FAIL dma_len5: got %0d want 5", dma_cycles); end
        n_cmp++; if (halt_n !== 1'b1) begin n_err++; $display("FAIL end_halt_n: got %b want 1", halt_n); end
        n_cmp++; if (dma_grant !== 1'b0) begin n_err++; $display("FAIL end_grant: got %b want 0", dma_grant); end
        n_cmp++; if (ab !== 16'h1F04) begin n_err++; $display("FAIL ab_hold_maria: got %h want 1f04", ab); end
        tick();
        n_cmp++; if (ab !== 16'h1F04) begin n_err++; $display("FAIL ab_hold_maria2: got %h want 1f04", ab); end
        cpu_released = 1'b0;
        #1;
        n_cmp++; if (ab !== 16'h2222) begin n_err++; $display("FAIL ab_back_cpu: got %h want 2222", ab); end
        n_cmp++; if (rw !== 1'b0) begin n_err++; $display("FAIL rw_back_cpu: got %b want 0", rw); end
        $display("dma_length: dma_cycles=%0d ab=%h", dma_cycles, ab);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int gap;
        dma_req = 1'b1;
        wait_halt(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_halt1: got halt_n=%b want 0", halt_n); end
        cpu_released = 1'b1;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_grant1: got grant=%b want 1", dma_grant); end
        repeat (2) pclk1_edge();
        dma_end = 1'b1;
        tick();
        dma_end = 1'b0;
        n_cmp++; if (dma_cycles !== 8'd2) begin n_err++; $display("FAIL b2b_len1: got %0d want 2", dma_cycles); end
        n_cmp++; if (halt_n !== 1'b1) begin n_err++; $display("FAIL b2b_end_halt_n: got %b want 1", halt_n); end
        cpu_released = 1'b0;
        gap = 0;
        for (int i = 0; i < 8; i++) begin
            pclk1_edge();
            if (halt_n === 1'b1) gap++;
            else break;
        end
        n_cmp++; if (gap !== 1) begin n_err++; $display("FAIL b2b_gap: got %0d pclk1 want 1", gap); end
        n_cmp++; if (halt_n !== 1'b0) begin n_err++; $display("FAIL b2b_halt2: got %b want 0", halt_n); end
        cpu_released = 1'b1;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_grant2: got grant=%b want 1", dma_grant); end
        repeat (2) pclk1_edge();
        repeat (3) tick();
        dma_end = 1'b1; dma_req = 1'b0;
        tick();
        dma_end = 1'b0;
        n_cmp++; if (dma_cycles !== 8'd3) begin n_err++; $display("FAIL b2b_len_same_pclk1: got %0d want 3", dma_cycles); end
        cpu_released = 1'b0;
        $display("back_to_back: gap=%0d dma_cycles=%0d", gap, dma_cycles);
    endtask

    task automatic test_timeout();
        bit ok;
        dma_req = 1'b1;
        wait_halt(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL to_halt: got halt_n=%b want 0", halt_n); end
        for (int i = 1; i <= 10; i++) begin
            pclk1_edge();
            if (i == 7) begin
                n_cmp++; if (halt_timeout !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", halt_timeout); end
            end
            if (i == 8) begin
                n_cmp++; if (halt_timeout !== 1'b1) begin n_err++; $display("FAIL to_at8: got %b want 1", halt_timeout); end
            end
        end
        n_cmp++; if (halt_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", halt_timeout); end
        n_cmp++; if (halt_n !== 1'b0) begin n_err++; $display("FAIL to_still_halting: got %b want 0", halt_n); end
        n_cmp++; if (dma_grant !== 1'b0) begin n_err++; $display("FAIL to_no_grant: got %b want 0", dma_grant); end
        tick();
        cpu_released = 1'b1;
        tick();
        n_cmp++; if (dma_grant !== 1'b0) begin n_err++; $display("FAIL grant_on_pclk0: got %b want 0", dma_grant); end
        tick();
        n_cmp++; if (dma_grant !== 1'b1) begin n_err++; $display("FAIL grant_after_pclk0: got %b want 1", dma_grant); end
        pclk1_edge();
        dma_end = 1'b1; dma_req = 1'b0;
        tick();
        dma_end = 1'b0;
        n_cmp++; if (dma_cycles !== 8'd1) begin n_err++; $display("FAIL to_len: got %0d want 1", dma_cycles); end
        cpu_released = 1'b0;
        $display("timeout: halt_timeout=%b dma_cycles=%0d", halt_timeout, dma_cycles);
    endtask

    task automatic test_halt_enable();
        bit ok;
        halt_enable = 1'b0;
        cpu_ab = 16'h4321;
        dma_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pclk1_edge();
            n_cmp++; if (halt_n !== 1'b1) begin n_err++; $display("FAIL he_blocked%0d: got %b want 1", i, halt_n); end
        end
        n_cmp++; if (ab !== 16'h4321) begin n_err++; $display("FAIL he_ab: got %h want 4321", ab); end
        halt_enable = 1'b1;
        tick();
        n_cmp++; if (halt_n !== 1'b1) begin n_err++; $display("FAIL he_not_yet: got %b want 1", halt_n); end
        pclk1_edge();
        n_cmp++; if (halt_n !== 1'b0) begin n_err++; $display("FAIL he_next_pclk1: got %b want 0", halt_n); end
        halt_enable = 1'b0;
        cpu_released = 1'b1;
        wait_grant(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL he_drop_no_abort: got grant=%b want 1", dma_grant); end
        $display("halt_enable: halt_n=%b grant=%b", halt_n, dma_grant);
    endtask

    task automatic test_reset_mid_dma();
        repeat (2) pclk1_edge();
        #3;
        reset = 1'b1;
        #1;
        n_cmp++; if (halt_n !== 1'b1) begin n_err++; $display("FAIL arst_halt_n: got %b want 1", halt_n); end
        n_cmp++; if (dma_grant !== 1'b0) begin n_err++; $display("FAIL arst_grant: got %b want 0", dma_grant); end
        n_cmp++; if (dma_cycles !== 8'd0) begin n_err++; $display("FAIL arst_dma_cycles: got %0d want 0", dma_cycles); end
        n_cmp++; if (halt_timeout !== 1'b0) begin n_err++; $display("FAIL arst_timeout: got %b want 0", halt_timeout); end
        n_cmp++; if (ab !== 16'h0000) begin n_err++; $display("FAIL arst_ab: got %h want 0000", ab); end
        tick();
        reset = 1'b0;
        dma_req = 1'b0;
        cpu_released = 1'b0;
        $display("reset_mid_dma: halt_n=%b grant=%b dma_cycles=%0d", halt_n, dma_grant, dma_cycles);
    endtask

    initial begin
        test_reset();
        test_halt_grant();
        test_dma_length();
        test_back_to_back();
        test_timeout();
        test_halt_enable();
        test_reset_mid_dma();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
